// File: rtl/eth_tx_frame_sequencer.sv
// ---------------------------------------------------------------------------
// eth_tx_frame_sequencer
//
// Purpose:
//   Emits one Ethernet TX frame for each accepted start pulse. Each frame is
//   FRAME_BYTES of payload read word-by-word from a 32-bit synchronous memory.
//   The words are presented on the MAC transmit FIFO interface (ff_tx_*) with
//   sop/eop/mod framing, and the block waits on ff_tx_rdy backpressure. After
//   each frame it inserts an inter-frame gap. New frames start only once the
//   MAC configuration is done.
//
//   Per word the block runs FETCH -> LOAD -> SEND, which is 3 cycles per word
//   when ff_tx_rdy is held high.
//
// Ports:
//   clk_hifreq     in   system clock
//   rst            in   synchronous, active-high reset
//   start          in   single-cycle frame trigger
//   cfg_done       in   MAC configuration complete; gates new frames only
//   mem_rd_en      out  memory read strobe; data is valid on mem_data next cycle
//   mem_addr       out  memory word address, (BASE_ADDR + word index) mod 256
//   mem_data       in   memory read data
//   ff_tx_rdy      in   MAC FIFO ready
//   ff_tx_data     out  frame word, byte 0 in [31:24]
//   ff_tx_wren     out  word valid
//   ff_tx_sop      out  first word of frame
//   ff_tx_eop      out  last word of frame
//   ff_tx_mod      out  number of invalid bytes in the eop word
//   ff_tx_err      out  tied to 0
//   busy           out  high whenever the sequencer is not idle
//   frame_count    out  completed frames, wraps
//   dropped_starts out  starts ignored while busy, saturates at 255
// ---------------------------------------------------------------------------
module eth_tx_frame_sequencer #(
    parameter int         FRAME_BYTES = 64,
    parameter logic [7:0] BASE_ADDR   = 8'd0,
    parameter int         IFG_CYCLES  = 12
) (
    input  logic        clk_hifreq,
    input  logic        rst,
    input  logic        start,
    input  logic        cfg_done,
    output logic        mem_rd_en,
    output logic [7:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        ff_tx_rdy,
    output logic [31:0] ff_tx_data,
    output logic        ff_tx_wren,
    output logic        ff_tx_sop,
    output logic        ff_tx_eop,
    output logic [1:0]  ff_tx_mod,
    output logic        ff_tx_err,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  dropped_starts
);

    localparam int         NWORDS   = (FRAME_BYTES + 3) / 4;
    localparam logic [7:0] LAST_IDX = 8'(NWORDS - 1);
    localparam logic [1:0] EOP_MOD  = 2'((4 - FRAME_BYTES % 4) % 4);
    // A gap of zero still spends one cycle in IFG before returning to IDLE.
    localparam logic [7:0] IFG_LAST = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_IFG
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q;
    logic [7:0]  ifg_cnt_q;
    logic [31:0] data_q;
    logic [15:0] frame_count_q;
    logic [7:0]  dropped_q;

    logic is_last;
    logic accept;

    assign is_last = (idx_q == LAST_IDX);
    assign accept  = (state_q == S_SEND) && ff_tx_rdy;

    // NOTE: every signal assigned in this block gets a default value first.
    // Without the defaults, a path that skips an assignment would infer a latch.
    always_comb begin
        state_d    = state_q;
        mem_rd_en  = 1'b0;
        mem_addr   = 8'd0;
        ff_tx_wren = 1'b0;
        ff_tx_sop  = 1'b0;
        ff_tx_eop  = 1'b0;
        ff_tx_mod  = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (start && cfg_done) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = BASE_ADDR + idx_q;    // 8-bit sum wraps mod 256
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                // While ff_tx_rdy is low these outputs are functions of state
                // and idx only, so they hold steady until the word is accepted.
                ff_tx_wren = 1'b1;
                ff_tx_sop  = (idx_q == 8'd0);
                ff_tx_eop  = is_last;
                ff_tx_mod  = is_last ? EOP_MOD : 2'd0;
                if (ff_tx_rdy) state_d = is_last ? S_IFG : S_FETCH;
            end
            S_IFG: begin
                if (ifg_cnt_q == IFG_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Then every
    // register samples the values from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk_hifreq) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= 8'd0;
            ifg_cnt_q     <= 8'd0;
            data_q        <= 32'd0;
            frame_count_q <= 16'd0;
            dropped_q     <= 8'd0;
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE)
                idx_q <= 8'd0;
            else if (accept && !is_last)
                idx_q <= idx_q + 8'd1;

            if (state_q == S_LOAD)
                data_q <= mem_data;

            if (state_q == S_IFG)
                ifg_cnt_q <= ifg_cnt_q + 8'd1;
            else
                ifg_cnt_q <= 8'd0;

            if (accept && is_last)
                frame_count_q <= frame_count_q + 16'd1;

            // A start in IFG is dropped too, including one on the cycle that
            // returns to IDLE.
            if (start && (state_q != S_IDLE) && (dropped_q != 8'hFF))
                dropped_q <= dropped_q + 8'd1;
        end
    end

    assign ff_tx_data     = data_q;
    assign ff_tx_err      = 1'b0;
    assign busy           = (state_q != S_IDLE);
    assign frame_count    = frame_count_q;
    assign dropped_starts = dropped_q;

endmodule
